// File: rtl/bp_gshare.sv
// rtl/bp_gshare.sv - saturating-counter branch predictor, gshare indexing when BP_HIST_EN is defined
module bp_gshare #(
    parameter int PC_W    = 14,
    parameter int IDX_W   = 10,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 8,
    parameter int FETCH_W = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PC_W-1:0]    r_pc,
    output logic [FETCH_W-1:0] is_taken,
    output logic [HIST_W-1:0]  r_ghr,
    output logic               ready,
    input  logic               is_b_ope,
    input  logic               is_branch,
    input  logic [PC_W-1:0]    w_pc,
    input  logic [HIST_W-1:0]  w_ghr
);
    localparam int DEPTH = 2**IDX_W;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W-1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [CTR_W-1:0]   table_q [DEPTH];
    logic               upd;
    logic [IDX_W-1:0]   hist_r, hist_w;
    logic [IDX_W-1:0]   idx_w;
    logic [CTR_W-1:0]   ctr_w, ctr_nxt;
    logic [IDX_W-1:0]   lane_idx [FETCH_W];

    // Only the low IDX_W bits of either PC reach the table; lane wrap is implicit modulo 2**IDX_W.
    wire unused_pc = ^{r_pc, w_pc};

    assign upd = is_b_ope & ready;

`ifdef BP_HIST_EN
    logic [HIST_W-1:0] ghr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ghr_q <= '0;
        else if (upd)
            ghr_q <= HIST_W'({ghr_q, is_branch});
    end

    assign r_ghr  = ghr_q;
    assign hist_r = IDX_W'(ghr_q);
    assign hist_w = IDX_W'(w_ghr);
`else
    wire unused_w_ghr = ^w_ghr;

    assign r_ghr  = '0;
    assign hist_r = '0;
    assign hist_w = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                ptr_q <= ptr_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && (&ptr_q))
            state_d = RUN;
    end

    always_comb begin
        ready = (state_q == RUN);
    end

    assign idx_w = w_pc[IDX_W-1:0] ^ hist_w;
    assign ctr_w = table_q[idx_w];

    always_comb begin
        ctr_nxt = ctr_w;
        if (is_branch) begin
            if (ctr_w != CTR_MAX)
                ctr_nxt = ctr_w + CTR_W'(1);
        end else begin
            if (ctr_w != '0)
                ctr_nxt = ctr_w - CTR_W'(1);
        end
    end

    // The sweep owns the table until RUN; resolved branches are dropped until then.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            table_q[ptr_q] <= WEAK_NT;
        else if (upd)
            table_q[idx_w] <= ctr_nxt;
    end

    always_comb begin
        lane_idx = '{default: '0};
        is_taken = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_idx[i] = (r_pc[IDX_W-1:0] + IDX_W'(i)) ^ hist_r;
            is_taken[i] = ready & table_q[lane_idx[i]][CTR_W-1];
        end
    end
endmodule

// File: tb/tb_bp_gshare.sv
// tb/tb_bp_gshare.sv - directed and randomized checks of bp_gshare against a behavioural predictor model
module tb_bp_gshare;
    localparam int PC_W    = 14;
    localparam int IDX_W   = 10;
    localparam int CTR_W   = 2;
    localparam int HIST_W  = 8;
    localparam int FETCH_W = 2;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int CMAX    = (1 << CTR_W) - 1;
`ifdef BP_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic [PC_W-1:0]    r_pc = '0;
    logic [FETCH_W-1:0] is_taken;
    logic [HIST_W-1:0]  r_ghr;
    logic               ready;
    logic               is_b_ope = 1'b0;
    logic               is_branch = 1'b0;
    logic [PC_W-1:0]    w_pc = '0;
    logic [HIST_W-1:0]  w_ghr = '0;

    int vectors = 0;
    int errors  = 0;

    int m_tbl [DEPTH];
    int m_cnt   = 0;
    bit m_ready = 1'b0;
    int m_ghr   = 0;

    bp_gshare #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .FETCH_W(FETCH_W)
    ) dut (
        .clk(clk), .rstn(rstn), .r_pc(r_pc), .is_taken(is_taken), .r_ghr(r_ghr),
        .ready(ready), .is_b_ope(is_b_ope), .is_branch(is_branch), .w_pc(w_pc), .w_ghr(w_ghr)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(int pc, int ghr);
        return (HIST_ON ? (pc ^ ghr) : pc) % DEPTH;
    endfunction

    function automatic logic [FETCH_W-1:0] m_pred(int pc);
        logic [FETCH_W-1:0] p;
        p = '0;
        for (int i = 0; i < FETCH_W; i++)
            p[i] = m_ready && (m_tbl[m_idx((pc + i) % (1 << PC_W), m_ghr)] >= (1 << (CTR_W-1)));
        return p;
    endfunction

    // Outputs are checked mid-cycle, then the model applies what the coming rising edge will do.
    always @(negedge clk) begin
        logic [FETCH_W-1:0] exp_t;
        int idx;
        if (!rstn) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            m_ghr   = 0;
        end
        exp_t = m_pred(int'(r_pc));
        vectors++;
        if (is_taken !== exp_t) begin
            errors++;
            $display("FAIL is_taken pc=%0h got %b expected %b t=%0t", r_pc, is_taken, exp_t, $time);
        end
        if (ready !== m_ready) begin
            errors++;
            $display("FAIL ready got %b expected %b t=%0t", ready, m_ready, $time);
        end
        if (r_ghr !== HIST_W'(m_ghr)) begin
            errors++;
            $display("FAIL r_ghr got %0h expected %0h t=%0t", r_ghr, m_ghr, $time);
        end
        if (rstn) begin
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_ready = 1'b1;
                    for (int j = 0; j < DEPTH; j++)
                        m_tbl[j] = (1 << (CTR_W-1)) - 1;
                end
            end else if (is_b_ope) begin
                idx = m_idx(int'(w_pc), int'(w_ghr));
                if (is_branch)
                    m_tbl[idx] = (m_tbl[idx] < CMAX) ? m_tbl[idx] + 1 : CMAX;
                else
                    m_tbl[idx] = (m_tbl[idx] > 0) ? m_tbl[idx] - 1 : 0;
                if (HIST_ON)
                    m_ghr = ((m_ghr << 1) | int'(is_branch)) % (1 << HIST_W);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd(input int pc, input bit tk, input int n, input int g);
        is_b_ope  = 1'b1;
        is_branch = tk;
        w_pc      = PC_W'(pc);
        w_ghr     = HIST_W'(g);
        repeat (n) step();
        is_b_ope  = 1'b0;
    endtask

    task automatic probe(input int pc, input int exp, input string nm);
        r_pc = PC_W'(pc);
        @(negedge clk);
        chk(nm, 32'(is_taken), exp);
        step();
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (ready === 1'b1)
                break;
            n++;
        end
        chk(nm, n, DEPTH);
        step();
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        wait_ready("init_len");
        probe(5, 0, "init_pc5");
        probe(12'h3A1, 0, "init_pc3a1");

`ifndef BP_HIST_EN
        upd(5, 1'b1, 3, 0);
        chk("model_ctr5", m_tbl[5], 3);
        probe(5, 1, "sat_t3");
        upd(5, 1'b1, 1, 0);
        upd(5, 1'b0, 1, 0);
        probe(5, 1, "sat_hi_nt1");
        upd(5, 1'b0, 1, 0);
        probe(5, 0, "sat_hi_nt2");
        upd(5, 1'b0, 3, 0);
        chk("model_ctr5_lo", m_tbl[5], 0);
        upd(5, 1'b1, 1, 0);
        probe(5, 0, "sat_lo_t1");
        upd(5, 1'b1, 1, 0);
        probe(5, 1, "sat_lo_t2");

        upd(10'h3FF, 1'b1, 2, 0);
        probe(10'h3FE, 2'b10, "dual_3fe");
        probe(14'h3FFF, 2'b01, "wrap_3fff");

        r_pc = 7; is_b_ope = 1'b1; is_branch = 1'b1; w_pc = 7;
        @(negedge clk);
        chk("simul_old", 32'(is_taken[0]), 0);
        step();
        is_b_ope = 1'b0;
        @(negedge clk);
        chk("simul_new", 32'(is_taken[0]), 1);
        step();
`else
        upd(8, 1'b1, 2, 0);
        upd(8, 1'b0, 1, 0);
        @(negedge clk);
        chk("ghr_ttn", 32'(r_ghr), 32'h06);
        step();
        upd(0, 1'b1, 2, 6);
        chk("model_ctr6", m_tbl[6], 3);
        probe(8'h1D, 2'b01, "hist_entry6");
        probe(8'h1B, 2'b00, "hist_entry0");
`endif

        for (int k = 0; k < 3000; k++) begin
            r_pc      = ($urandom_range(0, 3) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 40));
            is_b_ope  = 1'($urandom_range(0, 1));
            is_branch = 1'($urandom_range(0, 1));
            w_pc      = PC_W'($urandom_range(0, 40));
            w_ghr     = ($urandom_range(0, 1) == 1) ? HIST_W'(m_ghr) : HIST_W'($urandom);
            step();
        end
        is_b_ope = 1'b0;
        r_pc = 10'h3FE;

        rstn = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_ghr", 32'(r_ghr), 0);
        step();
        rstn = 1'b1;
        repeat (500) step();
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_ghr", 32'(r_ghr), 0);
        step();
        step();
        rstn = 1'b1;
        wait_ready("resweep_len");
        probe(10'h3FE, 0, "post_resweep");
        probe(5, 0, "post_resweep_pc5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
